siren_tone_meter: RTL and testbench

Receive-side counterpart to the siren generator. Samples a square-wave tone (e.g. the siren speaker line looped back, or an external pin) and measures its period in clk cycles. Reports tone presence and the sweep direction of the siren (pitch rising/falling). Used for on-board self-test of the siren and for tone-driven logic.

---
 rtl/siren_tone_meter.sv | 180 ++++++++++++++++++
 tb/tb_siren_tone_meter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/siren_tone_meter.sv
// Square-wave tone period meter with presence and sweep-direction flags.
// Optional TONE_AVG_EN: reported period is the mean of the last 4 accepted periods.
module siren_tone_meter #(
    parameter int CNT_W      = 20,
    parameter int TIMEOUT    = 1000000,
    parameter int MIN_PERIOD = 1000,
    parameter int HYST       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tone_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             tone_present,
    output logic             sweep_up,
    output logic             sweep_down
);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W:0]   HYST_C    = (CNT_W + 1)'(HYST);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, hist_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             present_q, present_d;
    logic             up_q, up_d;
    logic             down_q, down_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic             prev_ok_q, prev_ok_d;

    logic             edge_det;
    logic             accept;
    logic             meas_ok;
    logic [CNT_W-1:0] meas_val;
    logic [CNT_W:0]   new_w, prev_w;

`ifdef TONE_AVG_EN
    logic [CNT_W-1:0] hbuf_q [3];
    logic [CNT_W-1:0] hbuf_d [3];
    logic [1:0]       fill_q, fill_d;
    logic [CNT_W+1:0] sum;
`endif

    assign edge_det = sync2_q & ~hist_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        present_d = present_q;
        up_d      = up_q;
        down_d    = down_q;
        prev_d    = prev_q;
        prev_ok_d = prev_ok_q;
        accept    = 1'b0;
        meas_ok   = 1'b0;
        meas_val  = count_q;
        new_w     = '0;
        prev_w    = '0;
`ifdef TONE_AVG_EN
        hbuf_d    = hbuf_q;
        fill_d    = fill_q;
        sum       = '0;
`endif
        case (state_q)
            IDLE: begin
                if (edge_det) begin
                    count_d = CNT_W'(1);
                    state_d = MEASURE;
                end
            end
            default: begin
                if (edge_det && count_q >= MIN_C) begin
                    accept  = 1'b1;
                    count_d = CNT_W'(1);
                end else if (!edge_det && count_q == TIMEOUT_C) begin
                    state_d   = IDLE;
                    count_d   = '0;
                    period_d  = '0;
                    present_d = 1'b0;
                    up_d      = 1'b0;
                    down_d    = 1'b0;
                    prev_ok_d = 1'b0;
`ifdef TONE_AVG_EN
                    fill_d    = '0;
`endif
                end else begin
                    // Glitch edges fall through here: the measurement keeps running.
                    count_d = count_q + 1'b1;
                end
            end
        endcase

`ifdef TONE_AVG_EN
        if (accept) begin
            sum = (CNT_W + 2)'(count_q) + (CNT_W + 2)'(hbuf_q[0])
                + (CNT_W + 2)'(hbuf_q[1]) + (CNT_W + 2)'(hbuf_q[2]);
            hbuf_d[0] = count_q;
            for (int i = 1; i < 3; i++) hbuf_d[i] = hbuf_q[i-1];
            if (fill_q == 2'd3) begin
                meas_ok  = 1'b1;
                meas_val = sum[CNT_W+1:2];
            end else begin
                fill_d = fill_q + 1'b1;
            end
        end
`else
        meas_ok  = accept;
        meas_val = count_q;
`endif

        if (meas_ok) begin
            period_d  = meas_val;
            valid_d   = 1'b1;
            present_d = 1'b1;
            prev_d    = meas_val;
            prev_ok_d = 1'b1;
            new_w     = {1'b0, meas_val};
            prev_w    = {1'b0, prev_q};
            if (prev_ok_q) begin
                if (new_w + HYST_C < prev_w) begin
                    up_d   = 1'b1;
                    down_d = 1'b0;
                end else if (new_w > prev_w + HYST_C) begin
                    up_d   = 1'b0;
                    down_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            hist_q    <= 1'b0;
            count_q   <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            present_q <= 1'b0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            prev_q    <= '0;
            prev_ok_q <= 1'b0;
`ifdef TONE_AVG_EN
            fill_q    <= '0;
            for (int i = 0; i < 3; i++) hbuf_q[i] <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sync1_q   <= tone_in;
            sync2_q   <= sync1_q;
            hist_q    <= sync2_q;
            count_q   <= count_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            present_q <= present_d;
            up_q      <= up_d;
            down_q    <= down_d;
            prev_q    <= prev_d;
            prev_ok_q <= prev_ok_d;
`ifdef TONE_AVG_EN
            fill_q    <= fill_d;
            for (int i = 0; i < 3; i++) hbuf_q[i] <= hbuf_d[i];
`endif
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign tone_present = present_q;
    assign sweep_up     = up_q;
    assign sweep_down   = down_q;
endmodule

// File: tb/tb_siren_tone_meter.sv
// Scoreboard bench for siren_tone_meter: a behavioural model predicts each
// period_valid pulse (value, flags, latency) when the tone edge is driven.
module tb_siren_tone_meter;
    localparam int CNT_W      = 20;
    localparam int TIMEOUT    = 10000;
    localparam int MIN_PERIOD = 1000;
    localparam int HYST       = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tone_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             tone_present;
    logic             sweep_up;
    logic             sweep_down;

    siren_tone_meter #(
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .MIN_PERIOD(MIN_PERIOD), .HYST(HYST)
    ) dut (
        .clk(clk), .rst(rst), .tone_in(tone_in), .period(period),
        .period_valid(period_valid), .tone_present(tone_present),
        .sweep_up(sweep_up), .sweep_down(sweep_down)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int period;
        bit up;
        bit down;
        int cyc;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model of the meter.
    bit m_meas = 0, m_prev_ok = 0, m_up = 0, m_down = 0;
    int m_prev = 0, m_last = 0, m_fill = 0;
    int m_hist[4];

    task automatic model_clear();
        m_meas = 0; m_prev_ok = 0; m_up = 0; m_down = 0; m_fill = 0;
    endtask

    task automatic model_rise();
        int gap, val;
        if (!m_meas) begin
            m_meas = 1;
            m_last = cyc;
            return;
        end
        gap = cyc - m_last;
        if (gap < MIN_PERIOD) return;
        m_last = cyc;
`ifdef TONE_AVG_EN
        for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = gap;
        if (m_fill < 4) m_fill++;
        if (m_fill < 4) return;
        val = (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) >> 2;
`else
        val = gap;
`endif
        if (m_prev_ok) begin
            if (val + HYST < m_prev) begin m_up = 1; m_down = 0; end
            else if (val > m_prev + HYST) begin m_up = 0; m_down = 1; end
        end
        m_prev = val;
        m_prev_ok = 1;
        sb.push_back('{val, m_up, m_down, cyc});
        $display("push: period=%0d up=%0d down=%0d at cycle %0d", val, m_up, m_down, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tone(input bit v);
        if (v && !tone_in) model_rise();
        tone_in = v;
    endtask

    // One tone cycle of n clocks, high for 'high' clocks; g>0 adds a 20-cycle high glitch at offset g.
    task automatic wave(input int n, input int high, input int g);
        for (int i = 0; i < n; i++) begin
            set_tone((i < high) || (g > 0 && i >= g && i < g + 20));
            step();
        end
    endtask

    always @(negedge clk) begin
        if (period_valid) begin
            if (sb.size() == 0) begin
                check_eq("spurious_valid", period_valid, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("pulse: period=%0d up=%0d down=%0d present=%0d (exp %0d/%0d/%0d)",
                         period, sweep_up, sweep_down, tone_present, e.period, e.up, e.down);
                check_eq("period", period, e.period);
                check_eq("sweep_up", sweep_up, e.up);
                check_eq("sweep_down", sweep_down, e.down);
                check_eq("present", tone_present, 1);
                check_eq("latency", cyc - e.cyc, 3);
            end
        end
    end

    initial begin
        rst = 1'b1;
        tone_in = 1'b0;
        repeat (5) step();
        rst = 1'b0;
        repeat (100) step();
        check_eq("rst_period", period, 0);
        check_eq("rst_present", tone_present, 0);
        check_eq("rst_up", sweep_up, 0);
        check_eq("rst_down", sweep_down, 0);

        repeat (5) wave(2000, 1000, 0);
        wave(4000, 2000, 0);
        wave(3000, 1500, 0);
        wave(5000, 2500, 0);
        wave(5010, 2505, 0);
        wave(2000, 250, 500);
        wave(2000, 1000, 0);

        // Tone stops: drops out exactly TIMEOUT cycles after the last accepted detect.
        while (cyc < m_last + 2 + TIMEOUT) step();
        check_eq("to_present_before", tone_present, 1);
        step();
        check_eq("to_present", tone_present, 0);
        check_eq("to_period", period, 0);
        check_eq("to_up", sweep_up, 0);
        check_eq("to_down", sweep_down, 0);
        model_clear();

        repeat (6) wave(2000, 1000, 0);

        // Asynchronous reset in the middle of a measurement.
        set_tone(1'b1);
        repeat (1000) step();
        set_tone(1'b0);
        repeat (200) step();
        check_eq("pre_rst_present", tone_present, 1);
        check_eq("pre_rst_sb_empty", sb.size(), 0);
        rst = 1'b1;
        #2;
        check_eq("mid_rst_present", tone_present, 0);
        check_eq("mid_rst_period", period, 0);
        check_eq("mid_rst_up", sweep_up, 0);
        check_eq("mid_rst_down", sweep_down, 0);
        check_eq("mid_rst_valid", period_valid, 0);
        model_clear();
        repeat (3) step();
        rst = 1'b0;
        repeat (3) wave(2000, 1000, 0);
        repeat (20) step();
        check_eq("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
